// File: rtl/ascon_result_serializer.sv
// Captures the ASCON ciphertext and tag, then streams them out MSB-first, one byte per handshake.
// Define ASCON_SER_HEADER_EN to prefix each frame with a sync byte 0xA5 and a length byte.
module ascon_result_serializer #(
    parameter int CIPHER_BYTES = 184,
    parameter int TAG_BYTES    = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [8*CIPHER_BYTES-1:0] cipher_i,
    input  logic                      en_cipher_reg_i,
    input  logic [8*TAG_BYTES-1:0]    tag_i,
    input  logic                      en_tag_reg_i,
    output logic [7:0]                byte_o,
    output logic                      byte_valid_o,
    input  logic                      byte_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overrun_o
);

    localparam int PAYLOAD_BYTES = CIPHER_BYTES + TAG_BYTES;
`ifdef ASCON_SER_HEADER_EN
    localparam int HDR_BYTES = 2;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int FRAME_BYTES = PAYLOAD_BYTES + HDR_BYTES;
    localparam int REG_W       = FRAME_BYTES * 8;
    localparam int HEAD_W      = (HDR_BYTES + CIPHER_BYTES) * 8;
    localparam int TAG_W       = TAG_BYTES * 8;
    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_TAG, SEND, DONE} state_t;

    state_t           state;
    logic [REG_W-1:0] shift_reg;
    logic [7:0]       byte_count;
    logic             cipher_prev;
    logic             tag_prev;
    logic             cipher_edge;
    logic             tag_edge;
    logic [HEAD_W-1:0] head_cipher;

    assign cipher_edge = en_cipher_reg_i & ~cipher_prev;
    assign tag_edge    = en_tag_reg_i & ~tag_prev;

    // The header, when present, rides above the ciphertext so one shift path serves the whole frame.
`ifdef ASCON_SER_HEADER_EN
    assign head_cipher = {8'hA5, 8'(PAYLOAD_BYTES), cipher_i};
`else
    assign head_cipher = cipher_i;
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            shift_reg    <= '0;
            byte_count   <= '0;
            cipher_prev  <= 1'b0;
            tag_prev     <= 1'b0;
            byte_o       <= 8'h00;
            byte_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            cipher_prev <= en_cipher_reg_i;
            tag_prev    <= en_tag_reg_i;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cipher_edge) begin
                        shift_reg[REG_W-1 -: HEAD_W] <= head_cipher;
                        overrun_o <= 1'b0;
                        busy_o    <= 1'b1;
                        if (tag_edge) begin
                            shift_reg[TAG_W-1:0] <= tag_i;
                            byte_count   <= '0;
                            byte_o       <= head_cipher[HEAD_W-1 -: 8];
                            byte_valid_o <= 1'b1;
                            state        <= SEND;
                        end else begin
                            state <= WAIT_TAG;
                        end
                    end
                end
                WAIT_TAG: begin
                    if (cipher_edge) begin
                        overrun_o <= 1'b1;
                    end
                    if (tag_edge) begin
                        shift_reg[TAG_W-1:0] <= tag_i;
                        byte_count   <= '0;
                        byte_o       <= shift_reg[REG_W-1 -: 8];
                        byte_valid_o <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (cipher_edge || tag_edge) begin
                        overrun_o <= 1'b1;
                    end
                    // byte_o always mirrors the top of the register, so preload the next byte on accept.
                    if (byte_valid_o && byte_ready_i) begin
                        shift_reg  <= shift_reg << 8;
                        byte_count <= byte_count + 8'd1;
                        if (byte_count == LAST_IDX) begin
                            byte_o       <= 8'h00;
                            byte_valid_o <= 1'b0;
                            done_o       <= 1'b1;
                            state        <= DONE;
                        end else begin
                            byte_o <= shift_reg[REG_W-9 -: 8];
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ascon_result_serializer.md
Name: ascon_result_serializer

Overview:
Downstream stage of the ASCON control FSM. It captures the 1472-bit ciphertext and 128-bit tag when the FSM raises its register-enable strobes. It then streams the result out byte-by-byte, MSB first, over a valid/ready handshake toward the UART TX path. It raises a one-cycle done pulse when the last byte has been accepted.

Parameters:
CIPHER_BYTES, 184, ciphertext length in bytes (cipher_i width = 8*CIPHER_BYTES)
TAG_BYTES, 16, tag length in bytes (tag_i width = 8*TAG_BYTES)

Ports:
clock_i  in  1  system clock
reset_i  in  1  reset, asynchronous, active-low
cipher_i  in  8*CIPHER_BYTES  ciphertext from ASCON FSM
en_cipher_reg_i  in  1  cipher-valid strobe (level, may stay high many cycles)
tag_i  in  8*TAG_BYTES  tag from ASCON FSM
en_tag_reg_i  in  1  tag-valid strobe (level, may stay high many cycles)
byte_o  out  8  current output byte
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  sink accepts byte this cycle
busy_o  out  1  high from cipher capture until done
done_o  out  1  one-cycle pulse after last byte accepted
overrun_o  out  1  sticky: new capture edge seen while busy, cleared on next cipher capture in IDLE

Behaviour:
- Reset (async, reset_i=0): state IDLE; byte_o=0, byte_valid_o=0, busy_o=0, done_o=0, overrun_o=0; shift register, byte counter and edge-detect flops cleared.
- Both enables are rising-edge detected with a registered previous value. A strobe held high acts as one event.
- States: IDLE, WAIT_TAG, SEND, DONE.
- IDLE:
  - Rising edge of en_cipher_reg_i: load cipher_i into the upper 8*CIPHER_BYTES bits of a (CIPHER_BYTES+TAG_BYTES)*8-bit shift register. Clear overrun_o. Go to WAIT_TAG.
  - Both edges in the same cycle: load cipher and tag together, go directly to SEND.
- WAIT_TAG:
  - Rising edge of en_tag_reg_i: load tag_i into the low bits, clear the byte counter, go to SEND.
  - Further cipher edges here are ignored and set overrun_o.
- SEND:
  - byte_valid_o=1 and byte_o=shift_reg[MSB -: 8], both registered.
  - On byte_valid_o && byte_ready_i: shift left 8 and increment the counter.
  - When the counter reaches total-1 and the byte is accepted: go to DONE.
  - While ready is low, byte_o and byte_valid_o hold stable.
  - Cipher or tag edges here set overrun_o and are otherwise ignored.
- DONE: byte_valid_o=0, done_o=1 for exactly one cycle, busy_o drops, go to IDLE.
- busy_o = 1 in WAIT_TAG, SEND and DONE; 0 in IDLE.
- Throughput: one byte per cycle with ready held high. Total = CIPHER_BYTES+TAG_BYTES = 200 bytes.
- Latency: first byte_valid_o rises 1 cycle after the tag edge. done_o comes 1 cycle after the last accept.
- Counter width: 8 bits, sufficient for 200 (202 with header); no wrap in normal use.
- Byte order: cipher[MSB:MSB-7] first, ..., cipher[7:0], then tag[127:120], ..., tag[7:0].
- Reset mid-transfer: immediate abort, all outputs return to reset values, nothing is resumed.

Optional Feature:
ASCON_SER_HEADER_EN
- Defined: each frame is preceded by two header bytes: 0xA5 (sync), then 0xC8 (payload length = 200). They are sent in SEND before the payload under the same handshake. The counter terminates at 202 bytes.
- Undefined: no header; the frame is exactly 200 payload bytes.

Test Plan:
- Basic frame: cipher_i = 184 bytes 0x00..0xB7 incrementing, tag_i = 0xF0..0xFF. Pulse cipher then tag 5 cycles later, ready=1 → 200 bytes 0x00..0xB7 then 0xF0..0xFF on consecutive cycles, done_o pulses once, busy_o low afterwards.
- Backpressure: same data, ready toggling 1,0,0,1 → byte_o/valid stable while ready=0, no byte lost or duplicated, still 200 accepted bytes.
- Held strobes: en_cipher_reg_i high from capture to frame end and en_tag_reg_i high 3 cycles → exactly one frame sent, overrun_o stays 0.
- Simultaneous edges: both strobes rise in the same cycle from IDLE → frame starts next cycle with correct cipher and tag bytes.
- Overrun: new en_cipher_reg_i rising edge at byte 50 → overrun_o=1, frame output unchanged. overrun_o clears on the next IDLE capture.
- Reset mid-frame: assert reset_i at byte 100 → byte_valid_o=0 immediately, busy_o=0. A fresh capture afterwards produces a correct full frame (with ASCON_SER_HEADER_EN: first bytes 0xA5, 0xC8).
